// File: rtl/gray_seg7_scan.sv
// Gray-coded count consumer: synchronises and decodes the Gray word, converts it to BCD
// with a shift-add-3 FSM, and scans the result onto a 4-digit 7-segment display.
module gray_seg7_scan #(
    parameter int unsigned SCAN_DIV   = 16,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  GRAY,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic [15:0] BCD,
    output logic        VALID
);

    localparam int unsigned GW = 10;
    localparam int unsigned BW = 16;
    localparam int unsigned SW = BW + GW;
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = 4;
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LATCH} state_t;

    logic [GW-1:0] sync1_q, sync2_q, bin;
    logic [PW-1:0] ps_q;
    logic [1:0]    idx_q;
    logic          started_q;
    logic          tick, frame_start, start_req;

    state_t        state_q, state_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          valid_q, valid_d;

    // Two-flop synchroniser; the word is Gray so at most one bit is in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= GRAY;
            sync2_q <= sync1_q;
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(GW); i++) begin
            bin = bin ^ (sync2_q >> i);
        end
    end

    assign tick        = (ps_q == PS_MAX);
    assign frame_start = tick && (idx_q == 2'd3);
    assign start_req   = !started_q || frame_start;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ps_q      <= '0;
            idx_q     <= '0;
            started_q <= 1'b0;
        end else begin
            ps_q      <= tick ? '0 : ps_q + PW'(1);
            started_q <= 1'b1;
            if (tick) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    // Double-dabble: adjust BCD nibbles, then shift; ten shifts for a 10-bit input
    always_comb begin
        logic [SW-1:0] adj;
        state_d = state_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        adj     = shift_q;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    shift_d = {BW'(0), bin};
                    iter_d  = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                for (int n = 0; n < 4; n++) begin
                    if (adj[GW + 4*n +: 4] >= 4'd5) begin
                        adj[GW + 4*n +: 4] = adj[GW + 4*n +: 4] + 4'd3;
                    end
                end
                shift_d = {adj[SW-2:0], 1'b0};
                iter_d  = iter_q + IW'(1);
                if (iter_q == IW'(GW - 1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                bcd_d   = shift_q[SW-1:GW];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [3:0] digit;
    logic       blank;
    logic [6:0] seg_code, seg_on;
    logic [3:0] an_on;

    assign digit = bcd_q[4*idx_q +: 4];

    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ) begin
            case (idx_q)
                2'd3:    blank = (bcd_q[15:12] == 4'd0);
                2'd2:    blank = (bcd_q[15:8] == 8'd0);
                2'd1:    blank = (bcd_q[15:4] == 12'd0);
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (digit)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    end

    // Digit is dark until the first conversion lands, or when blanked as a leading zero
    assign an_on  = (valid_q && !blank) ? 4'(4'b0001 << idx_q) : 4'b0000;
    assign seg_on = (valid_q && !blank) ? seg_code : 7'h00;

    assign SEG   = ACTIVE_LOW ? ~seg_on : seg_on;
    assign AN    = ACTIVE_LOW ? ~an_on : an_on;
    assign BCD   = bcd_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_gray_seg7_scan.sv
// Scoreboarded random/directed bench for gray_seg7_scan: conversions are predicted from
// the Gray word sampled two edges before each load and checked when they are due.
module tb_gray_seg7_scan;

    localparam int unsigned SD = 8;
    localparam bit          AL = 1'b1;
    localparam bit          BZ = 1'b1;
    localparam int          FRAME = 4 * int'(SD);

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  GRAY;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic [15:0] BCD;
    logic        VALID;

    gray_seg7_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(AL), .BLANK_LZ(BZ)) dut (
        .CLK(CLK), .RST(RST), .GRAY(GRAY), .SEG(SEG), .AN(AN), .BCD(BCD), .VALID(VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t       sbq[$];
    logic [9:0] gray_at[int];
    int         n = 0;
    int         m_val = 0;
    bit         m_valid = 1'b0;
    int         n_latch = 0;
    int         n_vec = 0;
    int         n_fail = 0;

    logic [6:0] segtab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         p10[4] = '{1, 10, 100, 1000};

    function automatic int gray_to_int(input logic [9:0] g);
        for (int v = 0; v < 1024; v++) begin
            if (10'(v ^ (v >> 1)) == g) return v;
        end
        return -1;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s edge=%0d: got %0h, expected %0h", nm, n, act, want);
        end
    endtask

    // Request tracker: counts edges since reset and predicts each conversion
    always @(posedge CLK) begin
        if (RST) begin
            n = 0;
            sbq.delete();
            gray_at.delete();
        end else begin
            logic [9:0] src;
            n++;
            gray_at[n] = GRAY;
            if (n == 1 || (n % FRAME) == 0) begin
                src = (n >= 3) ? gray_at[n - 2] : 10'h000;
                sbq.push_back('{n + 11, gray_to_int(src)});
            end
        end
    end

    // Monitor: retire due conversions and check every output each cycle
    always @(posedge CLK) begin
        int         idx, dig;
        bit         blank;
        logic [6:0] es;
        logic [3:0] ea;
        #1;
        if (RST) begin
            m_val   = 0;
            m_valid = 1'b0;
        end else if (sbq.size() > 0 && sbq[0].due == n) begin
            exp_t e;
            e       = sbq.pop_front();
            m_val   = e.val;
            m_valid = 1'b1;
            n_latch++;
        end
        idx   = (n / int'(SD)) % 4;
        blank = BZ && idx > 0 && m_val < p10[idx];
        dig   = (m_val / p10[idx]) % 10;
        if (m_valid && !blank) begin
            ea = 4'(1 << idx);
            es = segtab[dig];
        end else begin
            ea = 4'h0;
            es = 7'h00;
        end
        if (AL) begin
            ea = ~ea;
            es = ~es;
        end
        check("VALID", int'(VALID), int'(m_valid));
        check("BCD", int'(BCD), int'(to_bcd(m_val)));
        check("AN", int'(AN), int'(ea));
        check("SEG", int'(SEG), int'(es));
    end

    task automatic hold(input logic [9:0] g, input int cycles);
        GRAY = g;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < FRAME + 1; k++) begin
            if ((n % FRAME) == ph) break;
            @(negedge CLK);
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST  = 1'b1;
        GRAY = 10'h3FF;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        hold(10'h3FF, 2 * FRAME);
        hold(10'h200, 2 * FRAME);
        hold(10'h004, 2 * FRAME);
        hold(10'h000, 2 * FRAME);
        hold(10'h00F, 2 * FRAME);
        // Input changes mid-conversion must not disturb the latched result
        hold(10'h200, FRAME);
        wait_phase(0);
        repeat (3) @(negedge CLK);
        hold(10'h004, 2 * FRAME);
        // Reset in the middle of a conversion
        hold(10'h200, FRAME);
        wait_phase(6);
        pulse_reset();
        hold(10'h200, 2 * FRAME);
        repeat (60) begin
            GRAY = 10'($urandom);
            repeat ($urandom_range(1, FRAME)) @(negedge CLK);
            if ($urandom_range(0, 15) == 0) pulse_reset();
        end
        hold(10'h2AA, 2 * FRAME);
        check("latch_seen", int'(n_latch > 10), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
